board_line_clear: RTL and testbench
===================================

// Module: board_line_clear
// PURPOSE
//  Writes the board RAM; collision detection only reads it. Run by the game controller after a piece has been locked into ram_board.
//  Scans the board bottom-up and finds full rows. Compacts the surviving rows downward, fills the vacated top rows with empty cells,
//  and reports how many lines were cleared. Uses the same enable/complete handshake as collision and draw_tetromino.
// PARAMETERS
//  BOARD_W   10  cells per row
//  BOARD_H   20  rows; row 0 = top
//  ADDR_W    8   ram_board address width; address = row*BOARD_W + col
//  COLOUR_W  6   cell width; 0 = empty
// PORTS
//  clk            in   1         clock
//  reset_n        in   1         synchronous, active-low reset
//  enable         in   1         held high by controller while block selected
//  ram_q          in   COLOUR_W  ram_board read data; valid 1 cycle after address
//  ram_addr       out  ADDR_W    ram_board address
//  ram_data       out  COLOUR_W  ram_board write data
//  ram_wren       out  1         ram_board write enable
//  lines_cleared  out  5         full rows removed in last run; held until next run starts
//  complete       out  1         one-cycle pulse when run finishes
// BEHAVIOUR
//  - Reset: state IDLE; ram_addr=0, ram_data=0, ram_wren=0, lines_cleared=0, complete=0; row buffer cleared.
//  - Pointers: src row r and dst row w, both loaded with BOARD_H-1 on leaving IDLE.
//    lines_cleared is also zeroed on leaving IDLE.
//  - IDLE: enable=1 -> READ, col=0.
//  - READ (BOARD_W+1 cycles): cycle k drives ram_addr=r*BOARD_W+k for k<BOARD_W.
//    Cycle k>=1 captures ram_q into buf[k-1]. After capture of col BOARD_W-1 -> EVAL.
//  - EVAL (1 cycle): full = all buf cells nonzero.
//    full: lines_cleared++, w unchanged.
//    not full, r!=w: -> WRITE.
//    not full, r==w: w--, no write.
//    Source-row exit, r>0: r--, next state READ.
//    Source-row exit, r==0: CLEAR_TOP if rows 0..w still need emptying, else DONE.
//  - WRITE (BOARD_W cycles): ram_wren=1, ram_addr=w*BOARD_W+k, ram_data=buf[k]. Then w--.
//    Then source-row exit as above (r>0 -> r--, READ; r==0 -> CLEAR_TOP/DONE).
//  - CLEAR_TOP: ram_wren=1, ram_data=0, writes every cell of rows w down to 0, col 0..BOARD_W-1 each. Then -> DONE.
//  - DONE: complete=1 for exactly this cycle. -> HOLD.
//  - HOLD: waits for enable=0, then IDLE. This prevents a re-run while the controller still holds enable high.
//  - ram_wren is 1 only in WRITE and CLEAR_TOP; it is 0 in every other state.
//  - enable=0 in any state other than IDLE/HOLD: abort to IDLE next cycle, ram_wren=0, complete never pulses.
//    The board may be left partly compacted; the controller must not drop enable mid-run.
//  - Pointer underflow: r and w are never decremented below 0. Use r==0 / all-rows-placed flags; no wrap-around.
//  - Simultaneous reset and enable: reset wins.
//  - lines_cleared saturates at BOARD_H. It equals BOARD_H only for an all-full board; CLEAR_TOP then writes all rows.
//  - Cycle cost: each source row = READ 11 + EVAL 1, plus WRITE 10 if r!=w. CLEAR_TOP = 10 per vacated row. DONE = 1.
// STRUCTURE
//  - Shared include board_defs.vh: BOARD_W, BOARD_H, ADDR_W, COLOUR_W, EMPTY_CELL=0, and the state encodings.
//    collision, draw_tetromino and controller use the same include.
//  - One sub-module, board_row_buffer: BOARD_W x COLOUR_W registers, write-by-index, read-by-index,
//    combinational full flag (all cells != EMPTY_CELL).
//  - Top level holds the FSM, pointers, column counter and address multiply-add (constant-width, row*10 = (row<<3)+(row<<1)).
// TESTING
//  Cycle 0 = first cycle enable=1 is seen in IDLE.
//  1. Empty board, enable held -> no ram_wren ever; complete in cycle 241 (20 rows x 12); lines_cleared=0;
//     then HOLD until enable drops.
//  2. Row 19 full (colour 6'h05), row 18 = single cell col 3 = 6'h12
//     -> row 19 = only col3=6'h12; row 18 all 0; lines_cleared=1.
//  3. Rows 16..19 full, rows 14,15 partial patterns
//     -> patterns land in rows 18,19; rows 0..17 zero; lines_cleared=4.
//  4. Non-adjacent full rows 19 and 17, row 18 partial, row 16 partial
//     -> row 18 to row 19, row 16 to row 18, rows 0..17 zero; lines_cleared=2.
//  5. All 200 cells nonzero -> all cells 0 after run; lines_cleared=20; exactly one complete pulse.
//  6. Drop enable during WRITE of test 2 -> ram_wren=0 next cycle, no complete.
//     Then a reset_n pulse mid-READ of a fresh run -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/board_line_clear_pkg.sv
// rtl/board_line_clear_pkg.sv - board geometry, line-clear FSM states and address helper
package board_line_clear_pkg;

    localparam int BOARD_W  = 10;
    localparam int BOARD_H  = 20;
    localparam int ADDR_W   = 8;
    localparam int COLOUR_W = 6;
    localparam int ROW_W    = 5;
    localparam int COL_W    = 4;
    localparam int LINES_W  = 5;

    localparam logic [COLOUR_W-1:0] EMPTY_CELL = '0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_EVAL,
        ST_WRITE,
        ST_CLEAR,
        ST_DONE,
        ST_HOLD
    } lc_state_e;

    // First address of a row: row*10 built as (row<<3)+(row<<1) at fixed width.
    function automatic logic [ADDR_W-1:0] row_base(input logic [ROW_W-1:0] row);
        logic [ADDR_W-1:0] row_w;
        row_w = {{(ADDR_W-ROW_W){1'b0}}, row};
        return (row_w << 3) + (row_w << 1);
    endfunction

endpackage

// File: rtl/board_row_buffer.sv
// rtl/board_row_buffer.sv - one board row of cells with indexed access and full flag
module board_row_buffer
    import board_line_clear_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                wr_en_i,
    input  logic [COL_W-1:0]    wr_idx_i,
    input  logic [COLOUR_W-1:0] wr_data_i,
    input  logic [COL_W-1:0]    rd_idx_i,
    output logic [COLOUR_W-1:0] rd_data_o,
    output logic                full_o
);

    logic [COLOUR_W-1:0] cells_q [BOARD_W];

    // Capture one cell per cycle; out-of-range indices are ignored.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < BOARD_W; i++) begin
                cells_q[i] <= EMPTY_CELL;
            end
        end else if (wr_en_i && (wr_idx_i < COL_W'(BOARD_W))) begin
            cells_q[wr_idx_i] <= wr_data_i;
        end
    end

    // Indexed read; an index past the row returns an empty cell.
    always_comb begin
        rd_data_o = EMPTY_CELL;
        if (rd_idx_i < COL_W'(BOARD_W)) begin
            rd_data_o = cells_q[rd_idx_i];
        end
    end

    // Row is full when no cell is empty.
    always_comb begin
        full_o = 1'b1;
        for (int i = 0; i < BOARD_W; i++) begin
            if (cells_q[i] == EMPTY_CELL) begin
                full_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/board_line_clear.sv
// rtl/board_line_clear.sv - removes full board rows, compacts survivors downward, counts lines
module board_line_clear
    import board_line_clear_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable_i,
    input  logic [COLOUR_W-1:0] ram_q_i,
    output logic [ADDR_W-1:0]   ram_addr_o,
    output logic [COLOUR_W-1:0] ram_data_o,
    output logic                ram_wren_o,
    output logic [LINES_W-1:0]  lines_cleared_o,
    output logic                complete_o
);

    localparam logic [ROW_W-1:0]   LAST_ROW  = ROW_W'(BOARD_H - 1);
    localparam logic [COL_W-1:0]   LAST_COL  = COL_W'(BOARD_W - 1);
    localparam logic [COL_W-1:0]   READ_END  = COL_W'(BOARD_W);
    localparam logic [LINES_W-1:0] LINES_MAX = LINES_W'(BOARD_H);

    lc_state_e           state_q;
    logic [ROW_W-1:0]    src_row_q;
    logic [ROW_W-1:0]    dst_row_q;
    logic [ROW_W-1:0]    dst_row_d;
    logic                placed_q;     // every row down to row 0 has received a survivor
    logic                placed_d;
    logic                dst_dec;
    logic                row_exit;
    logic [COL_W-1:0]    col_q;
    logic [ADDR_W-1:0]   ram_addr_q;
    logic [COLOUR_W-1:0] ram_data_q;
    logic                ram_wren_q;
    logic [LINES_W-1:0]  lines_q;
    logic                complete_q;

    logic                buf_wr_en;
    logic [COL_W-1:0]    buf_wr_idx;
    logic [COL_W-1:0]    buf_rd_idx;
    logic [COLOUR_W-1:0] buf_rd_data;
    logic                buf_full;

    // Read data lags the address by one cycle, so column k-1 lands while column k is addressed.
    assign buf_wr_en  = (state_q == ST_READ) && (col_q != '0);
    assign buf_wr_idx = col_q - 1'b1;
    // WRITE pre-fetches the next column so data stays aligned with the registered address.
    assign buf_rd_idx = (state_q == ST_WRITE) ? (col_q + 1'b1) : '0;

    board_row_buffer u_row_buffer (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en_i   (buf_wr_en),
        .wr_idx_i  (buf_wr_idx),
        .wr_data_i (ram_q_i),
        .rd_idx_i  (buf_rd_idx),
        .rd_data_o (buf_rd_data),
        .full_o    (buf_full)
    );

    // Destination pointer step: a survivor was placed in row w; stop at row 0 and flag it instead of wrapping.
    always_comb begin
        dst_dec   = 1'b0;
        dst_row_d = dst_row_q;
        placed_d  = placed_q;
        row_exit  = 1'b0;
        if (state_q == ST_EVAL && (buf_full || src_row_q == dst_row_q)) begin
            row_exit = 1'b1;
            dst_dec  = !buf_full;
        end
        if (state_q == ST_WRITE && col_q == LAST_COL) begin
            row_exit = 1'b1;
            dst_dec  = 1'b1;
        end
        if (dst_dec) begin
            if (dst_row_q == '0) begin
                placed_d = 1'b1;
            end else begin
                dst_row_d = dst_row_q - 1'b1;
            end
        end
    end

    // Line-clear sequencer with registered RAM and handshake outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            src_row_q  <= '0;
            dst_row_q  <= '0;
            placed_q   <= 1'b0;
            col_q      <= '0;
            ram_addr_q <= '0;
            ram_data_q <= EMPTY_CELL;
            ram_wren_q <= 1'b0;
            lines_q    <= '0;
            complete_q <= 1'b0;
        end else begin
            ram_wren_q <= 1'b0;
            ram_data_q <= EMPTY_CELL;
            complete_q <= 1'b0;
            dst_row_q  <= dst_row_d;
            placed_q   <= placed_d;
            case (state_q)
                ST_IDLE: begin
                    if (enable_i) begin
                        state_q    <= ST_READ;
                        src_row_q  <= LAST_ROW;
                        dst_row_q  <= LAST_ROW;
                        placed_q   <= 1'b0;
                        lines_q    <= '0;
                        col_q      <= '0;
                        ram_addr_q <= row_base(LAST_ROW);
                    end
                end
                ST_READ: begin
                    if (col_q == READ_END) begin
                        state_q <= ST_EVAL;
                    end else begin
                        col_q <= col_q + 1'b1;
                        if (col_q < LAST_COL) begin
                            ram_addr_q <= ram_addr_q + 1'b1;
                        end
                    end
                end
                ST_EVAL: begin
                    if (buf_full) begin
                        if (lines_q != LINES_MAX) begin
                            lines_q <= lines_q + 1'b1;
                        end
                    end else if (src_row_q != dst_row_q) begin
                        state_q    <= ST_WRITE;
                        col_q      <= '0;
                        ram_addr_q <= row_base(dst_row_q);
                        ram_data_q <= buf_rd_data;
                        ram_wren_q <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (col_q != LAST_COL) begin
                        col_q      <= col_q + 1'b1;
                        ram_addr_q <= ram_addr_q + 1'b1;
                        ram_data_q <= buf_rd_data;
                        ram_wren_q <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (col_q != LAST_COL) begin
                        col_q      <= col_q + 1'b1;
                        ram_addr_q <= ram_addr_q + 1'b1;
                        ram_wren_q <= 1'b1;
                    end else if (dst_row_q != '0) begin
                        dst_row_q  <= dst_row_q - 1'b1;
                        col_q      <= '0;
                        ram_addr_q <= row_base(dst_row_q - 1'b1);
                        ram_wren_q <= 1'b1;
                    end else begin
                        state_q    <= ST_DONE;
                        complete_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (!enable_i) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
            // Leaving a source row: next row up, or finish by emptying the vacated top rows.
            if (row_exit) begin
                col_q <= '0;
                if (src_row_q != '0) begin
                    src_row_q  <= src_row_q - 1'b1;
                    state_q    <= ST_READ;
                    ram_addr_q <= row_base(src_row_q - 1'b1);
                end else if (!placed_d) begin
                    state_q    <= ST_CLEAR;
                    ram_addr_q <= row_base(dst_row_d);
                    ram_wren_q <= 1'b1;
                end else begin
                    state_q    <= ST_DONE;
                    complete_q <= 1'b1;
                end
            end
            // Losing enable mid-run abandons the run without a completion pulse.
            if (!enable_i && state_q != ST_IDLE && state_q != ST_HOLD) begin
                state_q    <= ST_IDLE;
                ram_wren_q <= 1'b0;
                ram_data_q <= EMPTY_CELL;
                complete_q <= 1'b0;
            end
        end
    end

    assign ram_addr_o      = ram_addr_q;
    assign ram_data_o      = ram_data_q;
    assign ram_wren_o      = ram_wren_q;
    assign lines_cleared_o = lines_q;
    assign complete_o      = complete_q;

endmodule

// File: tb/tb_board_line_clear.sv
// tb/tb_board_line_clear.sv - self-checking bench for board_line_clear
module tb_board_line_clear;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b0;
    logic [5:0] ram_q;
    logic [7:0] ram_addr;
    logic [5:0] ram_data;
    logic       ram_wren;
    logic [4:0] lines_cleared;
    logic       complete;

    always #5 clk = ~clk;

    board_line_clear dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .enable_i        (enable),
        .ram_q_i         (ram_q),
        .ram_addr_o      (ram_addr),
        .ram_data_o      (ram_data),
        .ram_wren_o      (ram_wren),
        .lines_cleared_o (lines_cleared),
        .complete_o      (complete)
    );

    logic [5:0] mem      [200];
    logic [5:0] init_mem [200];
    logic [5:0] exp_mem  [200];
    logic       load_req = 1'b0;
    int         exp_lines;
    int         exp_moves;
    int         checks = 0;
    int         failures = 0;

    // Board RAM: one-cycle read latency, bench-side bulk load while the DUT is idle.
    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < 200; i++) mem[i] <= init_mem[i];
        end else if (ram_wren && ram_addr < 8'd200) begin
            mem[ram_addr] <= ram_data;
        end
        ram_q <= (ram_addr < 8'd200) ? mem[ram_addr] : 6'd0;
    end

    typedef struct {
        int id;
        int lines;
        int cycle;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic load_board();
        @(negedge clk);
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    task automatic build_board(input int id);
        for (int i = 0; i < 200; i++) init_mem[i] = 6'd0;
        case (id)
            2: begin
                for (int c = 0; c < 10; c++) init_mem[190 + c] = 6'h05;
                init_mem[183] = 6'h12;
            end
            3: begin
                for (int i = 160; i < 200; i++) init_mem[i] = 6'(1 + (i % 10));
                init_mem[150] = 6'h0A; init_mem[152] = 6'h0A; init_mem[154] = 6'h0A;
                init_mem[140] = 6'h01; init_mem[149] = 6'h3F;
            end
            4: begin
                for (int c = 0; c < 10; c++) begin
                    init_mem[190 + c] = 6'h05;
                    init_mem[170 + c] = 6'h09;
                end
                init_mem[180] = 6'h07;
                init_mem[165] = 6'h21; init_mem[166] = 6'h22;
            end
            5: begin
                for (int i = 0; i < 200; i++) init_mem[i] = 6'(1 + (i % 63));
            end
            default: ;
        endcase
    endtask

    task automatic random_board();
        int sel;
        for (int r = 0; r < 20; r++) begin
            sel = $urandom_range(0, 2);
            for (int c = 0; c < 10; c++) begin
                if (sel == 0) init_mem[r*10 + c] = 6'd0;
                else if (sel == 1) init_mem[r*10 + c] = 6'($urandom_range(1, 63));
                else init_mem[r*10 + c] = 6'($urandom_range(0, 63));
            end
            if (sel == 2) init_mem[r*10 + $urandom_range(0, 9)] = 6'd0;
        end
    endtask

    // Reference: keep non-full rows in bottom-up order, stack them from row 19 upward, empty the rest.
    task automatic model();
        int surv[$];
        int dst;
        bit full;
        surv = {};
        for (int r = 19; r >= 0; r--) begin
            full = 1'b1;
            for (int c = 0; c < 10; c++) if (init_mem[r*10 + c] == 6'd0) full = 1'b0;
            if (!full) surv.push_back(r);
        end
        exp_lines = 20 - surv.size();
        exp_moves = 0;
        for (int i = 0; i < 200; i++) exp_mem[i] = 6'd0;
        dst = 19;
        foreach (surv[i]) begin
            for (int c = 0; c < 10; c++) exp_mem[dst*10 + c] = init_mem[surv[i]*10 + c];
            if (surv[i] != dst) exp_moves++;
            dst--;
        end
    endtask

    task automatic run_and_check(input string name, input int tab_lines, input int tab_cycle);
        int cyc, ncpl, nwren, bad, exp_cycle;
        model();
        exp_cycle = 20*12 + 10*exp_moves + 10*exp_lines + 1;
        load_board();
        @(negedge clk);
        enable = 1'b1;
        cyc = -1; ncpl = 0; nwren = 0;
        for (int c = 1; c <= 1500 && cyc < 0; c++) begin
            @(posedge clk); #1;
            if (ram_wren) nwren++;
            if (complete) begin ncpl++; cyc = c; end
        end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (ram_wren) nwren++;
            if (complete) ncpl++;
        end
        check({name, " lines"}, int'(lines_cleared), exp_lines);
        if (tab_lines >= 0) check({name, " lines_tab"}, int'(lines_cleared), tab_lines);
        check({name, " complete_cycle"}, cyc, exp_cycle);
        if (tab_cycle >= 0) check({name, " complete_cycle_tab"}, cyc, tab_cycle);
        check({name, " complete_pulses"}, ncpl, 1);
        check({name, " wren_cycles"}, nwren, 10*(exp_moves + exp_lines));
        bad = 0;
        for (int i = 0; i < 200; i++) if (mem[i] !== exp_mem[i]) bad++;
        check({name, " board_cells_wrong"}, bad, 0);
        @(negedge clk);
        enable = 1'b0;
        @(posedge clk); #1;
        check({name, " lines_held_after_drop"}, int'(lines_cleared), exp_lines);
    endtask

    initial begin
        int seen, ncpl, nwren;

        vecs[0] = '{1, 0, 241};
        vecs[1] = '{2, 1, 441};
        vecs[2] = '{3, 4, 441};
        vecs[3] = '{4, 2, 441};
        vecs[4] = '{5, 20, 441};

        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", int'({ram_addr, ram_data, ram_wren, lines_cleared, complete}), 0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int v = 0; v < 5; v++) begin
            build_board(vecs[v].id);
            run_and_check($sformatf("test%0d", vecs[v].id), vecs[v].lines, vecs[v].cycle);
        end

        // Drop enable during the first WRITE of the test-2 board.
        build_board(2);
        load_board();
        @(negedge clk);
        enable = 1'b1;
        seen = 0;
        for (int c = 0; c < 100 && seen == 0; c++) begin
            @(posedge clk); #1;
            if (ram_wren) seen = 1;
        end
        check("abort_write_reached", seen, 1);
        @(negedge clk);
        enable = 1'b0;
        @(posedge clk); #1;
        check("abort_wren_next", int'(ram_wren), 0);
        ncpl = 0; nwren = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (complete) ncpl++;
            if (ram_wren) nwren++;
        end
        check("abort_no_complete", ncpl, 0);
        check("abort_no_wren", nwren, 0);

        // Reset pulse mid-READ of a fresh run, with enable still high.
        build_board(1);
        load_board();
        @(negedge clk);
        enable = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("midread_addr", int'(ram_addr), 193);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk); #1;
        check("midread_reset_outputs", int'({ram_addr, ram_data, ram_wren, lines_cleared, complete}), 0);
        @(posedge clk); #1;
        check("reset_beats_enable", int'({ram_addr, ram_data, ram_wren, lines_cleared, complete}), 0);
        @(negedge clk);
        reset_n = 1'b1;
        enable = 1'b0;
        @(negedge clk);

        for (int n = 0; n < 6; n++) begin
            random_board();
            run_and_check($sformatf("rand%0d", n), -1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
